// File: rtl/button_debouncer_if.sv
// Button bundle between the raw push-buttons, the debouncer and the input loader.
// Signal names match the debouncer's external port list.
interface button_debouncer_if #(
    parameter int NB_BUTTONS = 3
);
    logic [NB_BUTTONS-1:0] i_buttons;
    logic [NB_BUTTONS-1:0] o_pulses;
    logic [NB_BUTTONS-1:0] o_levels;

    modport master (output i_buttons, input o_pulses, input o_levels);
    modport slave  (input i_buttons, output o_pulses, output o_levels);
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus per-button debounce FSM for the ALU input loader.
// Emits a one-cycle press pulse and a debounced level for each button.
//
// state      | meaning
// -----------+------------------------------------------------------------
// RELEASED   | debounced level 0, input agrees
// PRESS_PEND | input high, counting stable cycles before accepting a press
// PRESSED    | debounced level 1, input agrees
// REL_PEND   | input low, counting stable cycles before accepting a release
module button_debouncer #(
    parameter int NB_BUTTONS      = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NB_COUNT        = 20
) (
    input  logic               i_clock,
    input  logic               i_reset,
    button_debouncer_if.slave  bus
);

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_PEND = 2'd1,
        PRESSED    = 2'd2,
        REL_PEND   = 2'd3
    } state_e;

    localparam logic [NB_COUNT-1:0] CNT_LAST = NB_COUNT'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB_COUNT-1:0] CNT_ONE  = NB_COUNT'(1);

    logic [NB_BUTTONS-1:0] sync1_q;
    logic [NB_BUTTONS-1:0] sync2_q;
    logic [NB_BUTTONS-1:0] level_q;
    logic [NB_BUTTONS-1:0] level_d;
    logic [NB_BUTTONS-1:0] pulse_q;
    logic [NB_BUTTONS-1:0] pulse_d;
    state_e                state_q [NB_BUTTONS];
    state_e                state_d [NB_BUTTONS];
    logic [NB_COUNT-1:0]   cnt_q   [NB_BUTTONS];
    logic [NB_COUNT-1:0]   cnt_d   [NB_BUTTONS];

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int b = 0; b < NB_BUTTONS; b++) begin
                state_q[b] <= RELEASED;
                cnt_q[b]   <= '0;
            end
        end else begin
            sync1_q <= bus.i_buttons;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int b = 0; b < NB_BUTTONS; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
        end
    end

    // Counter only advances while pending and stops at CNT_LAST, so it cannot wrap.
    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        for (int b = 0; b < NB_BUTTONS; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            case (state_q[b])
                RELEASED: begin
                    if (sync2_q[b]) begin
                        state_d[b] = PRESS_PEND;
                        cnt_d[b]   = CNT_ONE;
                    end
                end
                PRESS_PEND: begin
                    if (!sync2_q[b]) begin
                        state_d[b] = RELEASED;
                        cnt_d[b]   = '0;
                    end else if (cnt_q[b] == CNT_LAST) begin
                        state_d[b] = PRESSED;
                        level_d[b] = 1'b1;
                        pulse_d[b] = 1'b1;
                        cnt_d[b]   = '0;
                    end else begin
                        cnt_d[b] = cnt_q[b] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync2_q[b]) begin
                        state_d[b] = REL_PEND;
                        cnt_d[b]   = CNT_ONE;
                    end
                end
                REL_PEND: begin
                    if (sync2_q[b]) begin
                        state_d[b] = PRESSED;
                        cnt_d[b]   = '0;
                    end else if (cnt_q[b] == CNT_LAST) begin
                        state_d[b] = RELEASED;
                        level_d[b] = 1'b0;
                        cnt_d[b]   = '0;
                    end else begin
                        cnt_d[b] = cnt_q[b] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[b] = RELEASED;
                    cnt_d[b]   = '0;
                end
            endcase
        end
    end

    assign bus.o_pulses = pulse_q;
    assign bus.o_levels = level_q;

endmodule
